uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: the receiver's framing settings
// and the default geometry of the receive FIFO.
package uart_pkg;

    localparam int UART_OVERSAMPLE    = 16;
    localparam int UART_STOP_BITS     = 1;
    localparam int UART_PAYLOAD_BITS  = 8;
    localparam int UART_FIFO_DEPTH    = 16;
    // A FIFO entry is {break_flag, character}
    localparam int UART_ENTRY_BITS    = UART_PAYLOAD_BITS + 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the receive FIFO: one write port and one
// asynchronous read port. Contents are deliberately left unreset.
module uart_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {break, character} entries,
// tracks occupancy and almost-full, and latches a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
    parameter int DEPTH        = UART_FIFO_DEPTH,
    parameter int AFULL_LEVEL  = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rx_valid,
    input  logic [PAYLOAD_BITS-1:0]   rx_data,
    input  logic                      rx_break,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [PAYLOAD_BITS-1:0]   m_data,
    output logic                      m_break,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      rx_afull,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = PAYLOAD_BITS + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_afull;
    logic          r_ovf;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_evt;
    logic [LW-1:0] w_level_next;
    logic [EW-1:0] w_head;

    assign w_full    = (r_level == FULL_LVL);
    assign w_pop     = (r_level != '0) && m_ready;
    // A full FIFO still takes a character when the head leaves in the same cycle
    assign w_push    = rx_valid && (!w_full || w_pop);
    assign w_ovf_evt = rx_valid && w_full && !w_pop;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            r_afull <= (w_level_next >= AFULL_LVL);
            // A fresh overflow beats a simultaneous clear
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push && resetn),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({rx_break, rx_data}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    assign m_valid  = (r_level != '0);
    assign m_break  = w_head[EW-1];
    assign m_data   = w_head[PAYLOAD_BITS-1:0];
    assign level    = r_level;
    assign rx_afull = r_afull;
    assign ovf      = r_ovf;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=4, AFULL_LEVEL=2: a vector table of
// single-cycle steps plus a hand-written mid-operation reset sequence.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn, rx_valid, rx_break, m_ready, ovf_clr;
    logic [7:0] rx_data;
    logic       m_valid, m_break, rx_afull, ovf;
    logic [7:0] m_data;
    logic [2:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .PAYLOAD_BITS (8),
        .DEPTH        (4),
        .AFULL_LEVEL  (2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_break (rx_break),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_break  (m_break),
        .level    (level),
        .rx_afull (rx_afull),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    typedef struct {
        logic       rstn;
        logic       vld;
        logic [7:0] data;
        logic       brk;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_brk;
        logic [2:0] e_level;
        logic       e_afull;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rstn, logic vld, logic [7:0] data, logic brk,
                                logic rdy, logic clr, logic ev, logic [7:0] ed,
                                logic eb, logic [2:0] el, logic ea, logic eo);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.data = data; v.brk = brk;
        v.rdy = rdy; v.clr = clr; v.e_valid = ev; v.e_data = ed;
        v.e_brk = eb; v.e_level = el; v.e_afull = ea; v.e_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rstn, logic vld, logic [7:0] data, logic brk,
                         logic rdy, logic clr);
        resetn = rstn; rx_valid = vld; rx_data = data; rx_break = brk;
        m_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic ev, logic [7:0] ed, logic eb,
                         logic [2:0] el, logic ea, logic eo);
        cmp({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
        cmp({tag, ".level"},   32'(level),   32'(el));
        cmp({tag, ".rx_afull"},32'(rx_afull),32'(ea));
        cmp({tag, ".ovf"},     32'(ovf),     32'(eo));
        if (ev) begin
            cmp({tag, ".m_data"},  32'(m_data),  32'(ed));
            cmp({tag, ".m_break"}, 32'(m_break), 32'(eb));
        end
        $display("%s: valid=%0b data=%02h brk=%0b level=%0d afull=%0b ovf=%0b",
                 tag, m_valid, m_data, m_break, level, rx_afull, ovf);
    endtask

    initial begin
        //   rstn vld data  brk rdy clr | valid data brk lvl afull ovf
        // reset with a push held on the input: push must be ignored
        add(0, 1, 8'h99, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0);
        // single push, held with m_ready=0 for five cycles, then popped
        add(1, 1, 8'h41, 0, 0, 0,   1, 8'h41, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 0, 8'h00, 0, 0, 0, 1, 8'h41, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0);
        // fill, overflow with 0x14, drain in order
        add(1, 1, 8'h10, 0, 0, 0,   1, 8'h10, 0, 1, 0, 0);
        add(1, 1, 8'h11, 0, 0, 0,   1, 8'h10, 0, 2, 1, 0);
        add(1, 1, 8'h12, 0, 0, 0,   1, 8'h10, 0, 3, 1, 0);
        add(1, 1, 8'h13, 0, 0, 0,   1, 8'h10, 0, 4, 1, 0);
        add(1, 1, 8'h14, 0, 0, 0,   1, 8'h10, 0, 4, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h11, 0, 3, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h12, 0, 2, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h13, 0, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0, 0, 0);
        // full with simultaneous push and pop: 0x55 accepted, delivered last
        add(1, 1, 8'h20, 0, 0, 0,   1, 8'h20, 0, 1, 0, 0);
        add(1, 1, 8'h21, 0, 0, 0,   1, 8'h20, 0, 2, 1, 0);
        add(1, 1, 8'h22, 0, 0, 0,   1, 8'h20, 0, 3, 1, 0);
        add(1, 1, 8'h23, 0, 0, 0,   1, 8'h20, 0, 4, 1, 0);
        add(1, 1, 8'h55, 0, 1, 0,   1, 8'h21, 0, 4, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h22, 0, 3, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h23, 0, 2, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h55, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0);
        // empty with m_ready=1 still accepts a push; BREAK entry kept in order
        add(1, 1, 8'h31, 0, 1, 0,   1, 8'h31, 0, 1, 0, 0);
        add(1, 1, 8'h00, 1, 0, 0,   1, 8'h31, 0, 2, 1, 0);
        add(1, 1, 8'h32, 0, 0, 0,   1, 8'h31, 0, 3, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h00, 1, 2, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h32, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0);
        // overflow coinciding with ovf_clr: set wins; clear alone next cycle
        add(1, 1, 8'h40, 0, 0, 0,   1, 8'h40, 0, 1, 0, 0);
        add(1, 1, 8'h41, 0, 0, 0,   1, 8'h40, 0, 2, 1, 0);
        add(1, 1, 8'h42, 0, 0, 0,   1, 8'h40, 0, 3, 1, 0);
        add(1, 1, 8'h43, 0, 0, 0,   1, 8'h40, 0, 4, 1, 0);
        add(1, 1, 8'h44, 0, 0, 1,   1, 8'h40, 0, 4, 1, 1);
        add(1, 0, 8'h00, 0, 0, 1,   1, 8'h40, 0, 4, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h41, 0, 3, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h42, 0, 2, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0,   1, 8'h43, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0);

        resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_break = 1'b0;
        m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstn, vecs[i].vld, vecs[i].data, vecs[i].brk,
                  vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_brk, vecs[i].e_level, vecs[i].e_afull, vecs[i].e_ovf);
        end

        // mid-operation reset with a coinciding push, after forcing an overflow
        drive(1, 1, 8'h61, 0, 0, 0);
        drive(1, 1, 8'h62, 0, 0, 0);
        drive(1, 1, 8'h63, 0, 0, 0);
        check("fill3", 1, 8'h61, 0, 3'd3, 1, 0);
        drive(1, 1, 8'h64, 0, 0, 0);
        drive(1, 1, 8'h65, 0, 0, 0);
        check("ovf_before_rst", 1, 8'h61, 0, 3'd4, 1, 1);
        drive(0, 1, 8'h66, 0, 1, 0);
        check("rst_mid", 0, 8'h00, 0, 3'd0, 0, 0);
        drive(1, 1, 8'h7E, 0, 0, 0);
        check("post_rst_push", 1, 8'h7E, 0, 3'd1, 0, 0);
        drive(1, 1, 8'h7F, 0, 0, 0);
        check("post_rst_push2", 1, 8'h7E, 0, 3'd2, 1, 0);
        drive(1, 0, 8'h00, 0, 1, 0);
        check("post_rst_pop", 1, 8'h7F, 0, 3'd1, 0, 0);
        drive(1, 0, 8'h00, 0, 1, 0);
        check("post_rst_empty", 0, 8'h00, 0, 3'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo
